// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO built on an async-read dual-port RAM
// and two wrapping pointer counters. Optional cnt/afull ports: POWLIB_SFIFO_CNT_EN.

package powlib_pkg;

  function automatic int unsigned powlib_clogb2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// Dual-port RAM: one synchronous write port, one asynchronous read port.
module powlib_dpram #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = 3,
  parameter     ID   = "DPRAM"
) (
  input  logic            clk,
  input  logic            wr,
  input  logic [WIDX-1:0] wraddr,
  input  logic [W-1:0]    wrdata,
  input  logic [WIDX-1:0] rdaddr,
  output logic [W-1:0]    rddata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (wr) mem[wraddr] <= wrdata;
  end

  assign rddata = mem[rdaddr];

  if (D < 2) begin : g_bad_depth
    $error("%s: depth D must be at least 2", ID);
  end

endmodule

// Pointer counter that advances on adv and wraps from D-1 back to 0.
module powlib_cntr #(
  parameter int W = 3,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] LAST = W'(D - 1);

  always_ff @(posedge clk) begin
    if (rst)      value <= '0;
    else if (adv) value <= (value == LAST) ? '0 : value + 1'b1;
  end

endmodule

module powlib_sfifo
  import powlib_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int AFT  = D - 2,
  parameter int EDBG = 0,
  parameter     ID   = "SFIFO"
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy
`ifdef POWLIB_SFIFO_CNT_EN
  ,
  output logic [WIDX:0] cnt,
  output logic          afull
`endif
);

  localparam logic [WIDX:0] DEPTH = (WIDX + 1)'(D);

  logic [WIDX-1:0] wrptr;
  logic [WIDX-1:0] rdptr;
  logic [WIDX:0]   occ;
  logic [WIDX:0]   occ_nxt;
  logic            wr_acc;
  logic            rd_acc;

  // Reset drops both handshakes; wrrdy already carries !rst.
  assign wrrdy  = (occ != DEPTH) && !rst;
  assign rdvld  = (occ != '0);
  assign wr_acc = wrvld && wrrdy;
  assign rd_acc = rdvld && rdrdy && !rst;

  powlib_dpram #(
    .W    (W),
    .D    (D),
    .WIDX (WIDX),
    .ID   (ID)
  ) u_mem (
    .clk    (clk),
    .wr     (wr_acc),
    .wraddr (wrptr),
    .wrdata (wrdata),
    .rdaddr (rdptr),
    .rddata (rddata)
  );

  powlib_cntr #(
    .W (WIDX),
    .D (D)
  ) u_wrptr (
    .clk   (clk),
    .rst   (rst),
    .adv   (wr_acc),
    .value (wrptr)
  );

  powlib_cntr #(
    .W (WIDX),
    .D (D)
  ) u_rdptr (
    .clk   (clk),
    .rst   (rst),
    .adv   (rd_acc),
    .value (rdptr)
  );

  always_comb begin
    occ_nxt = occ;
    if (wr_acc && !rd_acc)      occ_nxt = occ + 1'b1;
    else if (rd_acc && !wr_acc) occ_nxt = occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) occ <= '0;
    else     occ <= occ_nxt;
  end

`ifdef POWLIB_SFIFO_CNT_EN
  localparam logic [WIDX:0] AFT_W = (WIDX + 1)'(AFT);

  assign cnt = occ;

  // Registered from the next occupancy so afull lines up with cnt.
  always_ff @(posedge clk) begin
    if (rst) afull <= 1'b0;
    else     afull <= (occ_nxt >= AFT_W);
  end
`endif

  if (AFT < 0 || AFT > D || EDBG < 0) begin : g_bad_param
    $error("%s: AFT must lie in 0..D and EDBG must be non-negative", ID);
  end

endmodule

// File: tb/tb_powlib_sfifo.sv
// Directed and randomized checks of powlib_sfifo at D=8 (instance a) and D=6 (instance b).
module tb_powlib_sfifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_rst = 1'b1, a_wrvld = 1'b0, a_rdrdy = 1'b0;
  logic        a_wrrdy, a_rdvld;
  logic [15:0] a_wrdata = '0, a_rddata;
  logic        b_rst = 1'b1, b_wrvld = 1'b0, b_rdrdy = 1'b0;
  logic        b_wrrdy, b_rdvld;
  logic [15:0] b_wrdata = '0, b_rddata;
`ifdef POWLIB_SFIFO_CNT_EN
  logic [3:0]  a_cnt, b_cnt;
  logic        a_afull, b_afull;
`endif

  powlib_sfifo #(.W(16), .D(8)) u_a (
    .clk    (clk),
    .rst    (a_rst),
    .wrdata (a_wrdata),
    .wrvld  (a_wrvld),
    .wrrdy  (a_wrrdy),
    .rddata (a_rddata),
    .rdvld  (a_rdvld),
    .rdrdy  (a_rdrdy)
`ifdef POWLIB_SFIFO_CNT_EN
    ,
    .cnt    (a_cnt),
    .afull  (a_afull)
`endif
  );

  powlib_sfifo #(.W(16), .D(6)) u_b (
    .clk    (clk),
    .rst    (b_rst),
    .wrdata (b_wrdata),
    .wrvld  (b_wrvld),
    .wrrdy  (b_wrrdy),
    .rddata (b_rddata),
    .rdvld  (b_rdvld),
    .rdrdy  (b_rdrdy)
`ifdef POWLIB_SFIFO_CNT_EN
    ,
    .cnt    (b_cnt),
    .afull  (b_afull)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; b_rst = 1'b1;
    tick; tick;
    total++; if (a_wrrdy !== 1'b0) begin bad++; $display("FAIL rst_wrrdy_forced: got %b want 0", a_wrrdy); end
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL rst_rdvld: got %b want 0", a_rdvld); end
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    total++; if (a_wrrdy !== 1'b1) begin bad++; $display("FAIL rst_a_wrrdy: got %b want 1", a_wrrdy); end
    total++; if (b_wrrdy !== 1'b1) begin bad++; $display("FAIL rst_b_wrrdy: got %b want 1", b_wrrdy); end
    total++; if (b_rdvld !== 1'b0) begin bad++; $display("FAIL rst_b_rdvld: got %b want 0", b_rdvld); end
`ifdef POWLIB_SFIFO_CNT_EN
    total++; if (a_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    total++; if (a_afull !== 1'b0) begin bad++; $display("FAIL rst_afull: got %b want 0", a_afull); end
`endif
  endtask

  task automatic test_latency;
    a_wrdata = 16'h00AB; a_wrvld = 1'b1;
    #1;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL lat_no_passthru: got %b want 0", a_rdvld); end
    tick;
    a_wrvld = 1'b0; a_wrdata = 'x;
    total++; if ({a_rdvld, a_rddata} !== {1'b1, 16'h00AB}) begin
      bad++; $display("FAIL lat_head: got vld=%b data=%h want vld=1 data=00ab", a_rdvld, a_rddata);
    end
    a_rdrdy = 1'b1;
    tick;
    a_rdrdy = 1'b0;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL lat_empty: got %b want 0", a_rdvld); end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= 8; i++) begin
      a_wrvld = 1'b1; a_wrdata = 16'(i);
      total++; if (a_wrrdy !== 1'b1) begin bad++; $display("FAIL fill_wrrdy[%0d]: got %b want 1", i, a_wrrdy); end
      tick;
    end
    total++; if (a_wrrdy !== 1'b0) begin bad++; $display("FAIL full_wrrdy: got %b want 0", a_wrrdy); end
    a_wrdata = 16'hDEAD;
    tick;
    a_wrvld = 1'b0; a_wrdata = 'x;
`ifdef POWLIB_SFIFO_CNT_EN
    total++; if (a_cnt !== 4'd8) begin bad++; $display("FAIL full_cnt: got %0d want 8", a_cnt); end
    total++; if (a_afull !== 1'b1) begin bad++; $display("FAIL full_afull: got %b want 1", a_afull); end
`endif
    a_rdrdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if ({a_rdvld, a_rddata} !== {1'b1, 16'(i)}) begin
        bad++; $display("FAIL drain[%0d]: got vld=%b data=%h want vld=1 data=%h", i, a_rdvld, a_rddata, 16'(i));
      end
      tick;
    end
    a_rdrdy = 1'b0;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL drain_empty: got %b want 0 (DEAD leaked?)", a_rdvld); end
    total++; if (a_wrrdy !== 1'b1) begin bad++; $display("FAIL drain_wrrdy: got %b want 1", a_wrrdy); end
  endtask

  task automatic test_full_simul;
    for (int i = 1; i <= 8; i++) begin
      a_wrvld = 1'b1; a_wrdata = 16'(16'h0100 + i);
      tick;
    end
    a_wrdata = 16'hBEEF; a_rdrdy = 1'b1;
    total++; if (a_wrrdy !== 1'b0) begin bad++; $display("FAIL fs_wrrdy_full: got %b want 0", a_wrrdy); end
    tick;
    a_wrvld = 1'b0; a_rdrdy = 1'b0; a_wrdata = 'x;
    total++; if (a_wrrdy !== 1'b1) begin bad++; $display("FAIL fs_wrrdy_after: got %b want 1", a_wrrdy); end
`ifdef POWLIB_SFIFO_CNT_EN
    total++; if (a_cnt !== 4'd7) begin bad++; $display("FAIL fs_cnt: got %0d want 7", a_cnt); end
`endif
    a_rdrdy = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      total++; if ({a_rdvld, a_rddata} !== {1'b1, 16'(16'h0100 + i)}) begin
        bad++; $display("FAIL fs_drain[%0d]: got vld=%b data=%h want vld=1 data=%h", i, a_rdvld, a_rddata, 16'(16'h0100 + i));
      end
      tick;
    end
    a_rdrdy = 1'b0;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL fs_empty: got %b want 0", a_rdvld); end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 5; i++) begin
      a_wrvld = 1'b1; a_wrdata = 16'(16'h0200 + i);
      tick;
    end
    a_wrvld = 1'b0; a_wrdata = 'x;
    a_rst = 1'b1;
    tick;
    a_rst = 1'b0;
    #1;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL mid_rdvld: got %b want 0", a_rdvld); end
    total++; if (a_wrrdy !== 1'b1) begin bad++; $display("FAIL mid_wrrdy: got %b want 1", a_wrrdy); end
`ifdef POWLIB_SFIFO_CNT_EN
    total++; if (a_cnt !== 4'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", a_cnt); end
`endif
    a_wrvld = 1'b1; a_wrdata = 16'h0055;
    tick;
    a_wrdata = 16'h0066;
    tick;
    a_wrvld = 1'b0; a_wrdata = 'x; a_rdrdy = 1'b1;
    total++; if ({a_rdvld, a_rddata} !== {1'b1, 16'h0055}) begin
      bad++; $display("FAIL mid_first: got vld=%b data=%h want vld=1 data=0055", a_rdvld, a_rddata);
    end
    tick;
    total++; if ({a_rdvld, a_rddata} !== {1'b1, 16'h0066}) begin
      bad++; $display("FAIL mid_second: got vld=%b data=%h want vld=1 data=0066", a_rdvld, a_rddata);
    end
    tick;
    a_rdrdy = 1'b0;
    total++; if (a_rdvld !== 1'b0) begin bad++; $display("FAIL mid_empty: got %b want 0", a_rdvld); end
  endtask

  task automatic test_wrap;
    b_wrvld = 1'b1; b_rdrdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b_wrdata = 16'(16'h0300 + k);
      #1;
      if (k == 0) begin
        total++; if (b_rdvld !== 1'b0) begin bad++; $display("FAIL wrap_start: got %b want 0", b_rdvld); end
      end else begin
        total++; if ({b_rdvld, b_rddata} !== {1'b1, 16'(16'h0300 + k - 1)}) begin
          bad++; $display("FAIL wrap[%0d]: got vld=%b data=%h want vld=1 data=%h", k, b_rdvld, b_rddata, 16'(16'h0300 + k - 1));
        end
`ifdef POWLIB_SFIFO_CNT_EN
        total++; if (b_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt[%0d]: got %0d want 1", k, b_cnt); end
`endif
      end
      tick;
    end
    b_wrvld = 1'b0; b_wrdata = 'x;
    total++; if ({b_rdvld, b_rddata} !== {1'b1, 16'h0313}) begin
      bad++; $display("FAIL wrap_last: got vld=%b data=%h want vld=1 data=0313", b_rdvld, b_rddata);
    end
    tick;
    b_rdrdy = 1'b0;
    total++; if (b_rdvld !== 1'b0) begin bad++; $display("FAIL wrap_empty: got %b want 0", b_rdvld); end
  endtask

  task automatic test_random;
    logic [15:0] q[$];
    logic        wacc, racc;
    logic [15:0] wd;
    int          wpct, rpct;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      wpct = ((cyc / 1000) % 2 == 0) ? 70 : 30;
      rpct = 100 - wpct;
      a_wrvld = ($urandom_range(0, 99) < 32'(wpct));
      a_rdrdy = ($urandom_range(0, 99) < 32'(rpct));
      a_wrdata = a_wrvld ? 16'($urandom) : 'x;
      wd = a_wrdata;
      #1;
      total++; if (a_wrrdy !== (q.size() != 8)) begin
        bad++; $display("FAIL rnd_wrrdy[%0d]: got %b want %b", cyc, a_wrrdy, (q.size() != 8));
      end
      total++; if (a_rdvld !== (q.size() != 0)) begin
        bad++; $display("FAIL rnd_rdvld[%0d]: got %b want %b", cyc, a_rdvld, (q.size() != 0));
      end
      if (q.size() != 0) begin
        total++; if (a_rddata !== q[0]) begin
          bad++; $display("FAIL rnd_data[%0d]: got %h want %h", cyc, a_rddata, q[0]);
        end
      end
`ifdef POWLIB_SFIFO_CNT_EN
      total++; if (a_cnt !== 4'(q.size())) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", cyc, a_cnt, q.size());
      end
      total++; if (a_afull !== (q.size() >= 6)) begin
        bad++; $display("FAIL rnd_afull[%0d]: got %b want %b", cyc, a_afull, (q.size() >= 6));
      end
`endif
      wacc = a_wrvld && (q.size() < 8);
      racc = a_rdrdy && (q.size() > 0);
      tick;
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(wd);
    end
    a_wrvld = 1'b0; a_rdrdy = 1'b0; a_wrdata = 'x;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_fill_drain;
    test_full_simul;
    test_reset_mid;
    test_wrap;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
